mdu_scheduler: RTL

MDU_SCHEDULER -- requirements
Module: mdu_scheduler

---
 rtl/mdu_scheduler.sv | 88 ++++++++
 1 files changed

// File: rtl/mdu_scheduler.sv
// mdu_scheduler: multi-cycle multiply/divide unit with HI/LO registers and pipeline stall request.
module mdu_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [2:0]  e_op,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        d_md,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        err
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t      state = IDLE;
    state_t      state_nx;
    logic [3:0]  cnt = '0;
    logic [3:0]  cnt_nx;
    logic [2:0]  op_q = '0;
    logic [31:0] a_q = '0;
    logic [31:0] b_q = '0;
    logic [31:0] hi_q = '0;
    logic [31:0] lo_q = '0;
    logic        err_q = 1'b0;
    logic        e_md, start, done, is_mul, sgn, na, nb;
    logic [31:0] ua, ub, uq, ur, q, r;
    logic [63:0] sa, sb, prod;
    assign e_md = e_op >= 3'd1 && e_op <= 3'd4;
    assign start = state == IDLE && e_valid && e_md;
    assign done = state == RUN && cnt == 4'd0;
    assign busy = state == RUN;
    assign stall_req = d_md & (busy | (e_valid & e_md));
    assign hi = hi_q;
    assign lo = lo_q;
    assign err = err_q;
    // One multiplier serves both flavours: sign-extend only for MULT.
    assign is_mul = op_q <= 3'd2;
    assign sgn = op_q == 3'd1 || op_q == 3'd3;
    assign sa = {{32{sgn & a_q[31]}}, a_q};
    assign sb = {{32{sgn & b_q[31]}}, b_q};
    assign prod = sa * sb;
    // Signed divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    assign na = sgn & a_q[31];
    assign nb = sgn & b_q[31];
    assign ua = na ? -a_q : a_q;
    assign ub = nb ? -b_q : b_q;
    assign uq = ub == 32'd0 ? 32'd0 : ua / ub;
    assign ur = ub == 32'd0 ? 32'd0 : ua % ub;
    assign q = (na ^ nb) ? -uq : uq;
    assign r = na ? -ur : ur;
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        if (start) begin
            state_nx = RUN;
            cnt_nx = e_op <= 3'd2 ? 4'(MULT_CYCLES - 1) : 4'(DIV_CYCLES - 1);
        end else if (done) begin
            state_nx = IDLE;
        end else if (state == RUN) begin
            cnt_nx = cnt - 4'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            op_q <= '0;
            a_q <= '0;
            b_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            if (start) {op_q, a_q, b_q} <= {e_op, e_rs, e_rt};
            if (done && (is_mul || b_q != 32'd0)) {hi_q, lo_q} <= is_mul ? prod : {r, q};
            if (state == IDLE && e_valid && e_op == 3'd5) hi_q <= e_rs;
            if (state == IDLE && e_valid && e_op == 3'd6) lo_q <= e_rs;
            if (state == RUN && e_valid && e_op >= 3'd1 && e_op <= 3'd6) err_q <= 1'b1;
        end
    end
endmodule
